// File: rtl/hd_pkg.sv
// Shared definitions for the SECDED Hamming decoder: widths, status encoding and
// the mapping between data-bit indices and Hamming codeword positions.
package hd_pkg;

  typedef enum logic [1:0] {
    HD_OK  = 2'd0,
    HD_SBE = 2'd1,
    HD_DBE = 2'd2
  } hd_status_e;

  localparam int HD_MAX_M = 11;

  function automatic int hd_m(input int k);
    if (k <= 1)         return 2;
    else if (k <= 4)    return 3;
    else if (k <= 11)   return 4;
    else if (k <= 26)   return 5;
    else if (k <= 57)   return 6;
    else if (k <= 120)  return 7;
    else if (k <= 247)  return 8;
    else if (k <= 502)  return 9;
    else if (k <= 1013) return 10;
    else                return 11;
  endfunction

  function automatic int hd_n(input int k);
    return k + hd_m(k) + 1;
  endfunction

  // 1-based codeword position of data bit idx; powers of two are parity slots.
  function automatic int hd_data_pos(input int idx);
    int pos;
    pos = idx + 1;
    for (int j = 0; j < HD_MAX_M; j++) begin
      if (pos >= (1 << j)) pos++;
    end
    return pos;
  endfunction

  function automatic int hd_syn_to_idx(input int s);
    int cnt;
    cnt = 0;
    for (int j = 0; j < HD_MAX_M; j++) begin
      if ((1 << j) < s) cnt++;
    end
    return s - cnt - 1;
  endfunction

endpackage

// File: rtl/hd_secded_classify.sv
// Combinational SECDED classification: turns syndrome and overall parity into
// corrected data plus mutually exclusive sbe/dbe flags.
module hd_secded_classify
  import hd_pkg::*;
#(
  parameter int K = 8,
  parameter int M = hd_m(K)
) (
  input  logic [M-1:0] syn,
  input  logic         par,
  input  logic [K-1:0] data,
  output logic [K-1:0] data_corr,
  output logic         sbe,
  output logic         dbe
);

  hd_status_e status;
  int         idx;
  logic       pow2;
  logic       data_hit;
  logic [K-1:0] flip;

  always_comb begin
    idx      = hd_syn_to_idx(int'(syn));
    pow2     = ((syn & (syn - 1'b1)) == '0);
    data_hit = par && (syn != '0) && !pow2 && (idx < K);
  end

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_flip
      assign flip[gi] = data_hit && (idx == gi);
    end
  endgenerate

  // Odd overall parity with a syndrome outside the data range means >=3 flips.
  always_comb begin
    status = HD_OK;
    if (syn == '0)
      status = par ? HD_SBE : HD_OK;
    else if (!par)
      status = HD_DBE;
    else if (pow2 || data_hit)
      status = HD_SBE;
    else
      status = HD_DBE;
  end

  assign data_corr = data ^ flip;
  assign sbe       = (status == HD_SBE);
  assign dbe       = (status == HD_DBE);

endmodule

// File: rtl/hd_secded_top.sv
// Three-stage SECDED Hamming decoder with valid/ready flow control.
// Optional saturating error counters are built when HD_ERR_CNT_EN is defined.
module hd_secded_top
  import hd_pkg::*;
#(
  parameter  int K  = 8,
  parameter  int CW = 16,
  localparam int M  = hd_m(K),
  localparam int N  = K + M + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  cin,
  input  logic          cvld,
  output logic          crdy,
  output logic [K-1:0]  dout,
  output logic          dvld,
  input  logic          drdy,
  output logic          sbe,
  output logic          dbe,
  output logic [CW-1:0] sbe_cnt,
  output logic [CW-1:0] dbe_cnt,
  input  logic          cnt_clr
);

  logic         en;
  logic         s1_vld_reg;
  logic [N-1:0] s1_cw_reg;
  logic         s2_vld_reg;
  logic [M-1:0] s2_syn_reg;
  logic         s2_par_reg;
  logic [K-1:0] s2_data_reg;
  logic [K-1:0] dout_reg;
  logic         dvld_reg;
  logic         sbe_reg;
  logic         dbe_reg;

  logic [M-1:0][K-1:0] cov;
  logic [M-1:0]        calc_par;
  logic [M-1:0]        syn_next;
  logic                par_next;
  logic [K-1:0]        corr_data;
  logic                corr_sbe;
  logic                corr_dbe;

  // The whole pipe moves together; it only stalls when a finished word is refused.
  assign en   = !dvld_reg || drdy;
  assign crdy = en;

  genvar gi, gj;
  generate
    for (gi = 0; gi < K; gi++) begin : g_cov_data
      localparam int POS = hd_data_pos(gi);
      for (gj = 0; gj < M; gj++) begin : g_cov_par
        assign cov[gj][gi] = (((POS >> gj) & 1) != 0) && s1_cw_reg[gi];
      end
    end
    for (gj = 0; gj < M; gj++) begin : g_calc_par
      assign calc_par[gj] = ^cov[gj];
    end
  endgenerate

  assign syn_next = s1_cw_reg[K+M-1:K] ^ calc_par;
  assign par_next = ^s1_cw_reg;

  hd_secded_classify #(
    .K (K),
    .M (M)
  ) u_classify (
    .syn       (s2_syn_reg),
    .par       (s2_par_reg),
    .data      (s2_data_reg),
    .data_corr (corr_data),
    .sbe       (corr_sbe),
    .dbe       (corr_dbe)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_reg  <= 1'b0;
      s1_cw_reg   <= '0;
      s2_vld_reg  <= 1'b0;
      s2_syn_reg  <= '0;
      s2_par_reg  <= 1'b0;
      s2_data_reg <= '0;
      dout_reg    <= '0;
      dvld_reg    <= 1'b0;
      sbe_reg     <= 1'b0;
      dbe_reg     <= 1'b0;
    end else if (en) begin
      s1_vld_reg  <= cvld;
      s1_cw_reg   <= cin;
      s2_vld_reg  <= s1_vld_reg;
      s2_syn_reg  <= syn_next;
      s2_par_reg  <= par_next;
      s2_data_reg <= s1_cw_reg[K-1:0];
      dout_reg    <= corr_data;
      dvld_reg    <= s2_vld_reg;
      sbe_reg     <= s2_vld_reg && corr_sbe;
      dbe_reg     <= s2_vld_reg && corr_dbe;
    end
  end

  assign dout = dout_reg;
  assign dvld = dvld_reg;
  assign sbe  = sbe_reg;
  assign dbe  = dbe_reg;

`ifdef HD_ERR_CNT_EN
  logic          xfer_out;
  logic [CW-1:0] sbe_cnt_reg;
  logic [CW-1:0] dbe_cnt_reg;

  assign xfer_out = dvld_reg && drdy;

  // Clear wins over a coincident event, which is simply lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sbe_cnt_reg <= '0;
      dbe_cnt_reg <= '0;
    end else if (cnt_clr) begin
      sbe_cnt_reg <= '0;
      dbe_cnt_reg <= '0;
    end else begin
      if (xfer_out && sbe_reg && (sbe_cnt_reg != '1))
        sbe_cnt_reg <= sbe_cnt_reg + 1'b1;
      if (xfer_out && dbe_reg && (dbe_cnt_reg != '1))
        dbe_cnt_reg <= dbe_cnt_reg + 1'b1;
    end
  end

  assign sbe_cnt = sbe_cnt_reg;
  assign dbe_cnt = dbe_cnt_reg;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign sbe_cnt        = '0;
  assign dbe_cnt        = '0;
`endif

endmodule

// File: tb/tb_hd_secded_top.sv
// Directed bench for hd_secded_top at K=8 (N=13); counter checks follow HD_ERR_CNT_EN.
module tb_hd_secded_top;

  localparam int K  = 8;
  localparam int N  = 13;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  cin = '0;
  logic          cvld = 1'b0;
  logic          crdy;
  logic [K-1:0]  dout;
  logic          dvld;
  logic          drdy = 1'b1;
  logic          sbe;
  logic          dbe;
  logic [CW-1:0] sbe_cnt;
  logic [CW-1:0] dbe_cnt;
  logic          cnt_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hd_secded_top #(.K(K), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .cin     (cin),
    .cvld    (cvld),
    .crdy    (crdy),
    .dout    (dout),
    .dvld    (dvld),
    .drdy    (drdy),
    .sbe     (sbe),
    .dbe     (dbe),
    .sbe_cnt (sbe_cnt),
    .dbe_cnt (dbe_cnt),
    .cnt_clr (cnt_clr)
  );

  typedef struct {
    string       name;
    logic [7:0]  data;
    logic [12:0] flip;
    logic [7:0]  exp_dout;
    logic        exp_sbe;
    logic        exp_dbe;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference encoder: data in non-power-of-2 positions 1..12, even parity per
  // position bit, overall parity over the other twelve bits.
  function automatic logic [12:0] enc(input logic [7:0] d);
    logic [12:1] code;
    logic [3:0]  par;
    int          k;
    code = '0;
    k    = 0;
    for (int p = 1; p <= 12; p++) begin
      if (p != 1 && p != 2 && p != 4 && p != 8) begin
        code[p] = d[k];
        k++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      par[j] = 1'b0;
      for (int p = 1; p <= 12; p++)
        if (((p >> j) & 1) == 1) par[j] = par[j] ^ code[p];
    end
    return {^{par, d}, par, d};
  endfunction

  task automatic send_one(input logic [12:0] w, output logic [7:0] d, output logic s,
                          output logic e, output bit ok);
    @(negedge clk);
    cin  = w;
    cvld = 1'b1;
    @(negedge clk);
    cvld = 1'b0;
    ok = 0; d = '0; s = 1'b0; e = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (dvld) begin
        ok = 1; d = dout; s = sbe; e = dbe;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       rs, re;
    bit         ok;
    logic [7:0] q[$];
    int         sent, got;
    logic       prev_stall;
    logic [7:0] prev_dout;
    bit         seen;

    // Vector table: 13 single flips of 0xA5, then doubles, a triple, clean words.
    for (int b = 0; b < 13; b++)
      vecs[b] = '{$sformatf("sbe_bit%0d", b), 8'hA5, 13'(1) << b, 8'hA5, 1'b1, 1'b0};
    vecs[13] = '{"dbe_3c_b0b5",   8'h3C, 13'h0021, 8'h1D, 1'b0, 1'b1};
    vecs[14] = '{"dbe_d0_p3",     8'hA5, 13'h0801, 8'hA4, 1'b0, 1'b1};
    vecs[15] = '{"dbe_idx_ge_k",  8'hA5, 13'h0112, 8'hB7, 1'b0, 1'b1};
    vecs[16] = '{"clean_00",      8'h00, 13'h0000, 8'h00, 1'b0, 1'b0};
    vecs[17] = '{"clean_ff",      8'hFF, 13'h0000, 8'hFF, 1'b0, 1'b0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_dvld", dvld, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_sts", {sbe, dbe}, 2'b00);
    check("rst_crdy", crdy, 1'b1);
    check("rst_cnt", {sbe_cnt, dbe_cnt}, 8'h00);
    rst = 1'b1;

    // Clean stream, one word per clock, 3-cycle latency
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      if (c < 3 || c >= 259)
        check("stream_bubble", dvld, 1'b0);
      else begin
        check("stream_word", {dvld, sbe, dbe, dout}, {3'b100, 8'(c - 3)});
        $display("stream out %02h sbe=%0b dbe=%0b", dout, sbe, dbe);
      end
      check("stream_crdy", crdy, 1'b1);
      cvld = (c < 256);
      cin  = enc(8'(c));
    end
    @(negedge clk);
    cvld = 1'b0;

    // Table-driven error vectors
    for (int v = 0; v < 18; v++) begin
      send_one(enc(vecs[v].data) ^ vecs[v].flip, rd, rs, re, ok);
      $display("vec %s data=%02h flip=%04h -> dout=%02h sbe=%0b dbe=%0b",
               vecs[v].name, vecs[v].data, vecs[v].flip, rd, rs, re);
      check({vecs[v].name, "_done"}, ok, 1'b1);
      check({vecs[v].name, "_dout"}, rd, vecs[v].exp_dout);
      check({vecs[v].name, "_sts"}, {rs, re}, {vecs[v].exp_sbe, vecs[v].exp_dbe});
    end
    @(negedge clk);
    @(negedge clk);
`ifndef HD_ERR_CNT_EN
    check("cnt_tied_sbe", sbe_cnt, 4'd0);
    check("cnt_tied_dbe", dbe_cnt, 4'd0);
`else
    check("cnt_tbl_dbe", dbe_cnt, 4'd3);
`endif

    // Backpressure: drdy alternates, cvld random
    sent = 0; got = 0; prev_stall = 1'b0; prev_dout = '0;
    for (int cyc = 0; cyc < 220; cyc++) begin
      @(negedge clk);
      drdy = (cyc >= 200) || (cyc % 2 == 0);
      cvld = (cyc < 200) && ($urandom_range(0, 1) == 1);
      cin  = enc(8'(sent));
      #1;
      if (prev_stall) begin
        check("bp_hold_dvld", dvld, 1'b1);
        check("bp_hold_dout", dout, prev_dout);
      end
      if (dvld && drdy) begin
        check("bp_not_spurious", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          check("bp_order", dout, q[0]);
          void'(q.pop_front());
        end
        $display("bp out %02h", dout);
        got++;
      end
      if (cvld && crdy) begin
        q.push_back(8'(sent));
        sent++;
      end
      prev_stall = dvld && !drdy;
      prev_dout  = dout;
    end
    check("bp_count", got, sent);
    check("bp_drained", q.size(), 0);

    // Reset with three words in flight
    @(negedge clk);
    drdy = 1'b1;
    cin = enc(8'h11); cvld = 1'b1;
    @(negedge clk);
    cin = enc(8'h22);
    @(negedge clk);
    cin = enc(8'h33);
    @(negedge clk);
    cvld = 1'b0;
    rst  = 1'b0;
    #1;
    check("mrst_dvld", dvld, 1'b0);
    check("mrst_dout", dout, 8'h00);
    check("mrst_crdy", crdy, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("mrst_hold_dvld", dvld, 1'b0);
    check("mrst_cnt", {sbe_cnt, dbe_cnt}, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    cin = enc(8'h44); cvld = 1'b1;
    @(negedge clk);
    cvld = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (dvld) begin
        seen = 1;
        $display("post-reset out %02h", dout);
        check("mrst_first_word", dout, 8'h44);
      end else
        @(negedge clk);
    end
    check("mrst_seen", seen, 1'b1);
    @(negedge clk);

`ifdef HD_ERR_CNT_EN
    // Saturating single-error counter and clear priority
    for (int i = 0; i < 20; i++) begin
      send_one(enc(8'(i)) ^ (13'(1) << (i % 13)), rd, rs, re, ok);
      check("cnt_sbe_word", {ok, rs}, 2'b11);
      @(negedge clk);
      $display("cnt word %0d sbe_cnt=%0d", i, sbe_cnt);
      if (i == 13) check("cnt_sbe_14", sbe_cnt, 4'd14);
    end
    check("cnt_sbe_sat", sbe_cnt, 4'd15);
    for (int i = 0; i < 2; i++) begin
      send_one(enc(8'h5A) ^ 13'h0003, rd, rs, re, ok);
      check("cnt_dbe_word", {ok, re}, 2'b11);
      @(negedge clk);
    end
    check("cnt_dbe_2", dbe_cnt, 4'd2);
    @(negedge clk);
    cin = enc(8'h77) ^ 13'h0004; cvld = 1'b1;
    @(negedge clk);
    cvld = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (dvld) seen = 1;
      else @(negedge clk);
    end
    check("clr_seen", {seen, sbe}, 2'b11);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    $display("clr sbe_cnt=%0d dbe_cnt=%0d", sbe_cnt, dbe_cnt);
    check("clr_sbe_cnt", sbe_cnt, 4'd0);
    check("clr_dbe_cnt", dbe_cnt, 4'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
